product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 153 +++++++++++++++
 tb/tb_product_accumulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums a sequence of 1..2^LEN_W signed 64-bit products
// into a guarded accumulator and hands the result downstream with a
// valid/ready handshake. The accumulator never wraps internally, and OVF_o
// flags a result outside the signed 64-bit range.
// Optional feature macro: PRODUCT_ACC_SAT_EN
//   defined   -> DOUT_o is saturated to the signed 64-bit range
//   undefined -> DOUT_o is the low 64 bits of the accumulator (wrapped)
module product_accumulator #(
  parameter int LEN_W = 8
) (
  input  logic             CLK_i,
  input  logic             RSTN_i,
  input  logic             CLR_i,
  input  logic [LEN_W-1:0] LEN_i,
  input  logic [63:0]      PROD_i,
  input  logic             PVALID_i,
  output logic             PREADY_o,
  output logic [63:0]      DOUT_o,
  output logic             OVF_o,
  output logic             DVALID_o,
  input  logic             DREADY_i,
  output logic             BUSY_o
);

  localparam int ACC_W = 64 + LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic               dvalid_q;

  logic               take;
  logic [LEN_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   prod_ext;
  logic               acc_ovf;

  // The handshake qualifiers; reset and clear both block acceptance.
  assign PREADY_o = RSTN_i && !CLR_i && (state_q != DONE);
  assign take     = PVALID_i && PREADY_o;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign prod_ext = {{LEN_W{PROD_i[63]}}, PROD_i};

  // The result fits in 64 signed bits only when every guard bit equals bit 63.
  assign acc_ovf  = !((&acc_q[ACC_W-1:63]) || !(|acc_q[ACC_W-1:63]));

  // Registered FSM state.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a clear always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (CLR_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            state_d = (LEN_i == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (take && (cnt_inc == len_q)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (DREADY_i) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Accumulator, term counter, latched length and registered result-valid.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= (state_d == DONE);
      if (CLR_i) begin
        acc_q <= '0;
        cnt_q <= '0;
        len_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (take) begin
              acc_q <= prod_ext;
              len_q <= LEN_i;
              cnt_q <= '0;
            end
          end
          ACCUM: begin
            if (take) begin
              acc_q <= acc_q + prod_ext;
              cnt_q <= cnt_inc;
            end
          end
          DONE: begin
            if (DREADY_i) begin
              acc_q <= '0;
            end
          end
          default: begin
            acc_q <= '0;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

`ifdef PRODUCT_ACC_SAT_EN
  // Clamp the result to the signed 64-bit range when it overflows.
  always_comb begin
    DOUT_o = acc_q[63:0];
    if (acc_ovf) begin
      DOUT_o = acc_q[ACC_W-1] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
  end
`else
  // Present the low 64 bits of the accumulator; overflow wraps.
  always_comb begin
    DOUT_o = acc_q[63:0];
  end
`endif

  assign OVF_o    = dvalid_q && acc_ovf;
  assign DVALID_o = dvalid_q;
  assign BUSY_o   = (state_q != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vectors with hand-computed results for
// product_accumulator, checked with immediate assertions.
module tb_product_accumulator;

  logic        clk_i;
  logic        rstn_i;
  logic        clr_i;
  logic [7:0]  len_i;
  logic [63:0] prod_i;
  logic        pvalid_i;
  logic        pready_o;
  logic [63:0] dout_o;
  logic        ovf_o;
  logic        dvalid_o;
  logic        dready_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.LEN_W(8)) dut (
    .CLK_i    (clk_i),
    .RSTN_i   (rstn_i),
    .CLR_i    (clr_i),
    .LEN_i    (len_i),
    .PROD_i   (prod_i),
    .PVALID_i (pvalid_i),
    .PREADY_o (pready_o),
    .DOUT_o   (dout_o),
    .OVF_o    (ovf_o),
    .DVALID_o (dvalid_o),
    .DREADY_i (dready_i),
    .BUSY_o   (busy_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic applyStimulus(input logic valid, input logic [63:0] prod,
                               input logic [7:0] len, input logic clr,
                               input logic dready);
    pvalid_i = valid;
    prod_i   = prod;
    len_i    = len;
    clr_i    = clr;
    dready_i = dready;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  localparam logic [63:0] P62     = 64'h4000_0000_0000_0000;
  localparam logic [63:0] MINV    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXV    = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rstn_i = 1'b0;
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    #2;
    $display("[TB] reset state");
    checkOutput("rst_pready", 64'(pready_o), 64'd0);
    checkOutput("rst_dvalid", 64'(dvalid_o), 64'd0);
    checkOutput("rst_busy",   64'(busy_o),   64'd0);
    checkOutput("rst_dout",   dout_o,        64'd0);
    checkOutput("rst_ovf",    64'(ovf_o),    64'd0);
    #10;
    rstn_i = 1'b1;
    tick();
    checkOutput("idle_pready", 64'(pready_o), 64'd1);
    checkOutput("idle_busy",   64'(busy_o),   64'd0);

    $display("[TB] basic sum 5 - 3 + 10");
    applyStimulus(1'b1, 64'd5, 8'd2, 1'b0, 1'b0);
    tick();
    checkOutput("sum_busy1",   64'(busy_o),   64'd1);
    checkOutput("sum_dvalid1", 64'(dvalid_o), 64'd0);
    applyStimulus(1'b1, -64'sd3, 8'd2, 1'b0, 1'b0);
    tick();
    checkOutput("sum_dvalid2", 64'(dvalid_o), 64'd0);
    applyStimulus(1'b1, 64'd10, 8'd2, 1'b0, 1'b0);
    tick();
    checkOutput("sum_dvalid3", 64'(dvalid_o), 64'd1);
    checkOutput("sum_dout",    dout_o,        64'd12);
    checkOutput("sum_ovf",     64'(ovf_o),    64'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 64'd99, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_dvalid", 64'(dvalid_o), 64'd1);
      checkOutput("bp_dout",   dout_o,        64'd12);
      checkOutput("bp_pready", 64'(pready_o), 64'd0);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_rel_dvalid", 64'(dvalid_o), 64'd0);
    checkOutput("bp_rel_busy",   64'(busy_o),   64'd0);

    $display("[TB] positive overflow 4 x 2^62");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, P62, 8'd3, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("povf_dvalid", 64'(dvalid_o), 64'd1);
    checkOutput("povf_ovf",    64'(ovf_o),    64'd1);
`ifdef PRODUCT_ACC_SAT_EN
    checkOutput("povf_dout", dout_o, MAXV);
`else
    checkOutput("povf_dout", dout_o, 64'd0);
`endif
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();

    $display("[TB] negative overflow -2^63 - 1");
    applyStimulus(1'b1, MINV, 8'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, NEG_ONE, 8'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("novf_ovf", 64'(ovf_o), 64'd1);
`ifdef PRODUCT_ACC_SAT_EN
    checkOutput("novf_dout", dout_o, MINV);
`else
    checkOutput("novf_dout", dout_o, MAXV);
`endif
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();

    $display("[TB] clear race");
    applyStimulus(1'b1, 64'd7, 8'd2, 1'b0, 1'b0);
    tick();
    checkOutput("clr_busy_pre", 64'(busy_o), 64'd1);
    applyStimulus(1'b1, 64'd9, 8'd2, 1'b1, 1'b0);
    #1;
    checkOutput("clr_pready", 64'(pready_o), 64'd0);
    tick();
    checkOutput("clr_busy",   64'(busy_o),   64'd0);
    checkOutput("clr_dvalid", 64'(dvalid_o), 64'd0);
    applyStimulus(1'b1, -64'sd4, 8'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("clr_next_dvalid", 64'(dvalid_o), 64'd1);
    checkOutput("clr_next_dout",   dout_o,        -64'sd4);
    checkOutput("clr_next_ovf",    64'(ovf_o),    64'd0);
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();

    $display("[TB] asynchronous reset mid-sequence");
    applyStimulus(1'b1, 64'd1, 8'd3, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 64'd2, 8'd3, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 8'd3, 1'b0, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("arst_busy",   64'(busy_o),   64'd0);
    checkOutput("arst_dout",   dout_o,        64'd0);
    checkOutput("arst_pready", 64'(pready_o), 64'd0);
    checkOutput("arst_dvalid", 64'(dvalid_o), 64'd0);
    checkOutput("arst_ovf",    64'(ovf_o),    64'd0);
    #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("arst_no_result", 64'(dvalid_o), 64'd0);
    end
    applyStimulus(1'b1, 64'd3, 8'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("arst_new_dvalid", 64'(dvalid_o), 64'd1);
    checkOutput("arst_new_dout",   dout_o,        64'd3);
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();

    $display("[TB] length latch");
    applyStimulus(1'b1, 64'd100, 8'd1, 1'b0, 1'b0);
    tick();
    checkOutput("len_dvalid1", 64'(dvalid_o), 64'd0);
    applyStimulus(1'b1, 64'd200, 8'd7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 8'd7, 1'b0, 1'b0);
    checkOutput("len_dvalid2", 64'(dvalid_o), 64'd1);
    checkOutput("len_dout",    dout_o,        64'd300);
    applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("len_idle_busy", 64'(busy_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
